// File: rtl/vx_mem_line_adapter.sv
// rtl/vx_mem_line_adapter.sv - line-wide tagged memory port to word-wide in-order memory bridge
//
// Purpose:
//   Splits each Vortex line request into word transactions. A line read issues
//   N pipelined word reads and reassembles the in-order word responses into one
//   tagged line response. A line write issues one byte-enabled word write per
//   word slice that has any byte enable set; all-zero slices are skipped.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   mem_req_*          line request from Vortex (valid/ready handshake)
//   mem_rsp_*          line read response to Vortex (valid/ready handshake)
//   word_req_*         word request to local memory (valid/ready handshake)
//   word_rsp_*         word read data from local memory (valid only, in order)
//   proto_err          sticky flag: word response with no read outstanding

module vx_mem_line_adapter #(
  parameter int LINE_W = 512,
  parameter int WORD_W = 32,
  parameter int ADDR_W = 26,
  parameter int TAG_W  = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,

  input  logic                                     mem_req_valid,
  input  logic                                     mem_req_rw,
  input  logic [LINE_W/8-1:0]                      mem_req_byteen,
  input  logic [ADDR_W-1:0]                        mem_req_addr,
  input  logic [LINE_W-1:0]                        mem_req_data,
  input  logic [TAG_W-1:0]                         mem_req_tag,
  output logic                                     mem_req_ready,

  output logic                                     mem_rsp_valid,
  output logic [LINE_W-1:0]                        mem_rsp_data,
  output logic [TAG_W-1:0]                         mem_rsp_tag,
  input  logic                                     mem_rsp_ready,

  output logic                                     word_req_valid,
  output logic                                     word_req_rw,
  output logic [ADDR_W+$clog2(LINE_W/WORD_W)-1:0]  word_req_addr,
  output logic [WORD_W/8-1:0]                      word_req_byteen,
  output logic [WORD_W-1:0]                        word_req_data,
  input  logic                                     word_req_ready,

  input  logic                                     word_rsp_valid,
  input  logic [WORD_W-1:0]                        word_rsp_data,

  output logic                                     proto_err
);

  localparam int N      = LINE_W / WORD_W;
  localparam int IDX_W  = $clog2(N);
  localparam int CNT_W  = IDX_W + 1;   // counts 0..N inclusive
  localparam int BE_W   = WORD_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RSP  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]   addr_q;
  logic [TAG_W-1:0]    tag_q;
  // Holds write data during WR and is overwritten slot by slot with read
  // data during RD, so it doubles as the response line buffer.
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W/8-1:0] byteen_q;
  logic [CNT_W-1:0]    iss_q;
  logic [CNT_W-1:0]    rcv_q;
  logic [IDX_W-1:0]    idx_q;
  logic                proto_err_q;

  logic                accept;
  logic                rd_issue;
  logic                rd_fire;
  logic                rsp_take;
  logic                rsp_last;
  logic [BE_W-1:0]     wr_slice_be;
  logic [WORD_W-1:0]   wr_slice_data;
  logic                wr_slice_live;
  logic                wr_step;

  // ---------------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    accept        = mem_req_valid && (state == S_IDLE);
    rd_issue      = (state == S_RD) && (iss_q != CNT_W'(N));
    rd_fire       = rd_issue && word_req_ready;
    // A response is only legal while some issued read is still unanswered.
    rsp_take      = (state == S_RD) && word_rsp_valid && (rcv_q != iss_q);
    rsp_last      = rsp_take && (rcv_q == CNT_W'(N - 1));
    wr_slice_be   = byteen_q[idx_q*BE_W +: BE_W];
    wr_slice_data = line_q[idx_q*WORD_W +: WORD_W];
    wr_slice_live = (state == S_WR) && (wr_slice_be != '0);
    // Empty slices are skipped in a single cycle without a word request.
    wr_step       = (state == S_WR) && ((wr_slice_be == '0) || word_req_ready);
  end

  // ---------------------------------------------------------------------------
  // Next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt       = state;
    mem_req_ready   = 1'b0;
    mem_rsp_valid   = 1'b0;
    word_req_valid  = 1'b0;
    word_req_rw     = 1'b0;
    word_req_addr   = {addr_q, idx_q};
    word_req_byteen = '0;
    word_req_data   = '0;

    case (state)
      S_IDLE: begin
        mem_req_ready = 1'b1;
        if (mem_req_valid) begin
          state_nxt = mem_req_rw ? S_WR : S_RD;
        end
      end

      S_RD: begin
        word_req_valid  = rd_issue;
        word_req_addr   = {addr_q, iss_q[IDX_W-1:0]};
        word_req_byteen = '1;
        if (rsp_last) begin
          state_nxt = S_RSP;
        end
      end

      S_RSP: begin
        mem_rsp_valid = 1'b1;
        if (mem_rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end

      S_WR: begin
        word_req_valid  = wr_slice_live;
        word_req_rw     = 1'b1;
        word_req_addr   = {addr_q, idx_q};
        word_req_byteen = wr_slice_be;
        word_req_data   = wr_slice_data;
        if (wr_step && (idx_q == IDX_W'(N - 1))) begin
          state_nxt = S_IDLE;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_rsp_data = line_q;
  assign mem_rsp_tag  = tag_q;
  assign proto_err    = proto_err_q;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      tag_q       <= '0;
      line_q      <= '0;
      byteen_q    <= '0;
      iss_q       <= '0;
      rcv_q       <= '0;
      idx_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        addr_q   <= mem_req_addr;
        tag_q    <= mem_req_tag;
        line_q   <= mem_req_data;
        byteen_q <= mem_req_byteen;
        iss_q    <= '0;
        rcv_q    <= '0;
        idx_q    <= '0;
      end

      // Issue and receive counters are independent so a word accept and a
      // word response in the same cycle both take effect.
      if (rd_fire) begin
        iss_q <= iss_q + CNT_W'(1);
      end

      if (rsp_take) begin
        line_q[rcv_q[IDX_W-1:0]*WORD_W +: WORD_W] <= word_rsp_data;
        rcv_q <= rcv_q + CNT_W'(1);
      end

      if (wr_step) begin
        idx_q <= idx_q + IDX_W'(1);
      end

      if (word_rsp_valid && !rsp_take) begin
        proto_err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vx_mem_line_adapter.sv
// tb/tb_vx_mem_line_adapter.sv - scoreboard bench for vx_mem_line_adapter
module tb_vx_mem_line_adapter;

  localparam int LINE_W = 512;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 26;
  localparam int TAG_W  = 8;
  localparam int N      = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                mem_req_valid;
  logic                mem_req_rw;
  logic [63:0]         mem_req_byteen;
  logic [25:0]         mem_req_addr;
  logic [511:0]        mem_req_data;
  logic [7:0]          mem_req_tag;
  logic                mem_req_ready;
  logic                mem_rsp_valid;
  logic [511:0]        mem_rsp_data;
  logic [7:0]          mem_rsp_tag;
  logic                mem_rsp_ready;
  logic                word_req_valid;
  logic                word_req_rw;
  logic [29:0]         word_req_addr;
  logic [3:0]          word_req_byteen;
  logic [31:0]         word_req_data;
  logic                word_req_ready;
  logic                word_rsp_valid;
  logic [31:0]         word_rsp_data;
  logic                proto_err;

  vx_mem_line_adapter #(
    .LINE_W(LINE_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready),
    .word_req_valid(word_req_valid), .word_req_rw(word_req_rw),
    .word_req_addr(word_req_addr), .word_req_byteen(word_req_byteen),
    .word_req_data(word_req_data), .word_req_ready(word_req_ready),
    .word_rsp_valid(word_rsp_valid), .word_rsp_data(word_rsp_data),
    .proto_err(proto_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: line-level view of memory plus expectation queues
  // ---------------------------------------------------------------------------
  typedef struct { bit [7:0] tag; bit [511:0] line; } rsp_t;
  typedef struct { bit [29:0] addr; bit [3:0] be; bit [31:0] data; } wr_t;

  bit [31:0] ref_mem [bit [29:0]];
  bit [31:0] mem     [bit [29:0]];
  rsp_t      exp_rsp[$];
  wr_t       exp_wr[$];
  bit [29:0] exp_raddr[$];

  function automatic bit [31:0] dflt(bit [29:0] a);
    return {2'b00, a} ^ 32'h3C00_0000;
  endfunction

  function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] d, bit [3:0] be);
    bit [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic model_line(input bit rw, input bit [25:0] a, input bit [63:0] be,
                            input bit [511:0] d, input bit [7:0] tag);
    bit [29:0]  wa;
    bit [511:0] line;
    rsp_t       r;
    wr_t        w;
    line = '0;
    for (int k = 0; k < N; k++) begin
      wa = {a, 4'(k)};
      if (rw) begin
        if (be[k*4 +: 4] != 4'h0) begin
          w.addr = wa; w.be = be[k*4 +: 4]; w.data = d[k*32 +: 32];
          exp_wr.push_back(w);
          ref_mem[wa] = merge(ref_mem.exists(wa) ? ref_mem[wa] : dflt(wa), w.data, w.be);
        end
      end else begin
        line[k*32 +: 32] = ref_mem.exists(wa) ? ref_mem[wa] : dflt(wa);
        exp_raddr.push_back(wa);
      end
    end
    if (!rw) begin
      r.tag = tag; r.line = line;
      exp_rsp.push_back(r);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Word memory responder and monitors (all activity on the falling edge)
  // ---------------------------------------------------------------------------
  typedef struct { int due; bit [31:0] d; } pend_t;
  pend_t pend[$];
  int    cyc = 0;
  int    ready_mode = 0;
  int    rsp_delay = 1;
  int    rsp_stall = 0;
  int    stall_cnt = 0;
  bit    spur_req = 1'b0;
  int    n_wwr = 0;
  int    n_wrd = 0;
  bit    prev_stall = 1'b0;
  logic [29:0]  held_addr;
  logic [31:0]  held_wdata;
  logic [3:0]   held_be;
  logic         held_rw;
  logic [511:0] held_line;
  logic [7:0]   held_tag;

  initial begin
    word_req_ready = 1'b0;
    word_rsp_valid = 1'b0;
    word_rsp_data  = '0;
    mem_rsp_ready  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        pend.delete();
        word_rsp_valid = 1'b0;
        word_req_ready = 1'b0;
        mem_rsp_ready  = 1'b0;
        stall_cnt      = 0;
        prev_stall     = 1'b0;
      end else begin
        if (spur_req) begin
          word_rsp_valid = 1'b1;
          word_rsp_data  = 32'h0BAD_0BAD;
          spur_req       = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
          word_rsp_valid = 1'b1;
          word_rsp_data  = pend[0].d;
          void'(pend.pop_front());
        end else begin
          word_rsp_valid = 1'b0;
        end

        case (ready_mode)
          0:       word_req_ready = 1'b1;
          1:       word_req_ready = cyc[0];
          default: word_req_ready = 1'($urandom_range(0, 1));
        endcase

        if (prev_stall) begin
          chk("req_hold_valid", word_req_valid, 1'b1);
          chk("req_hold_addr", word_req_addr, held_addr);
          chk("req_hold_fields", {word_req_rw, word_req_byteen, word_req_data},
              {held_rw, held_be, held_wdata});
        end
        prev_stall = word_req_valid && !word_req_ready;
        held_addr  = word_req_addr;
        held_rw    = word_req_rw;
        held_be    = word_req_byteen;
        held_wdata = word_req_data;

        if (word_req_valid && word_req_ready) begin
          if (word_req_rw) begin
            wr_t w;
            n_wwr++;
            if (exp_wr.size() == 0) fail_msg("unexpected_word_write");
            else begin
              w = exp_wr.pop_front();
              chk("wwr_addr", word_req_addr, w.addr);
              chk("wwr_be", word_req_byteen, w.be);
              chk("wwr_data", word_req_data, w.data);
            end
            mem[word_req_addr] = merge(mem.exists(word_req_addr) ? mem[word_req_addr]
                                       : dflt(word_req_addr), word_req_data, word_req_byteen);
          end else begin
            pend_t p;
            n_wrd++;
            chk("wrd_be", word_req_byteen, 4'hF);
            if (exp_raddr.size() == 0) fail_msg("unexpected_word_read");
            else chk("wrd_addr", word_req_addr, exp_raddr.pop_front());
            p.due = cyc + rsp_delay;
            p.d   = mem.exists(word_req_addr) ? mem[word_req_addr] : dflt(word_req_addr);
            pend.push_back(p);
          end
        end

        if (mem_rsp_valid) begin
          chk("busy_during_rsp", mem_req_ready, 1'b0);
          if (stall_cnt > 0) begin
            chk_line("rsp_hold_data", mem_rsp_data, held_line);
            chk("rsp_hold_tag", mem_rsp_tag, held_tag);
          end
          held_line = mem_rsp_data;
          held_tag  = mem_rsp_tag;
          if (stall_cnt < rsp_stall) begin
            mem_rsp_ready = 1'b0;
            stall_cnt++;
          end else begin
            rsp_t r;
            mem_rsp_ready = 1'b1;
            stall_cnt     = 0;
            if (exp_rsp.size() == 0) fail_msg("unexpected_line_rsp");
            else begin
              r = exp_rsp.pop_front();
              chk("rsp_tag", mem_rsp_tag, r.tag);
              chk_line("rsp_line", mem_rsp_data, r.line);
            end
          end
        end else begin
          mem_rsp_ready = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic send(input bit rw, input bit [25:0] a, input bit [63:0] be,
                      input bit [511:0] d, input bit [7:0] tag);
    int n = 0;
    @(negedge clk);
    mem_req_valid  = 1'b1;
    mem_req_rw     = rw;
    mem_req_addr   = a;
    mem_req_byteen = be;
    mem_req_data   = d;
    mem_req_tag    = tag;
    while (!mem_req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req_ready) fail_msg("req_accept_timeout");
    model_line(rw, a, be, d, tag);
    @(posedge clk);
    #1;
    mem_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(mem_req_ready && !mem_rsp_valid && exp_rsp.size() == 0 && exp_wr.size() == 0)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_msg("idle_timeout");
  endtask

  function automatic bit [511:0] rand_line();
    bit [511:0] l;
    for (int k = 0; k < N; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  initial begin
    bit [511:0] d;
    bit [63:0]  be;
    bit [25:0]  lines [4];
    int         k;
    int         base;

    lines[0] = 26'h10; lines[1] = 26'h20; lines[2] = 26'h33; lines[3] = 26'h3FF_FFFF;
    reset = 1'b1;
    mem_req_valid = 1'b0; mem_req_rw = 1'b0; mem_req_byteen = '0;
    mem_req_addr = '0; mem_req_data = '0; mem_req_tag = '0;
    for (int i = 0; i < N; i++) begin
      mem[{26'h10, 4'(i)}]     = 32'hA000_0000 + i;
      ref_mem[{26'h10, 4'(i)}] = 32'hA000_0000 + i;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", mem_req_ready, 1'b1);
    chk("rst_rsp_valid", mem_rsp_valid, 1'b0);
    chk("rst_word_valid", word_req_valid, 1'b0);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_rsp_tag", mem_rsp_tag, 8'h00);
    chk_line("rst_rsp_data", mem_rsp_data, '0);
    reset = 1'b0;

    // Zero-wait read: mem_rsp_valid 18 cycles after acceptance
    ready_mode = 0; rsp_delay = 1; rsp_stall = 0;
    send(1'b0, 26'h10, '0, '0, 8'h3C);
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_rsp_valid && k < 500);
    chk("read_latency", k, 18);
    wait_idle();

    // Full write then readback
    for (int i = 0; i < N; i++) d[i*32 +: 32] = 32'h5500_0000 + i;
    base = n_wwr;
    send(1'b1, 26'h20, '1, d, 8'h00);
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_req_ready && k < 500);
    chk("full_write_ready_again", k, 17);
    chk("full_write_count", n_wwr - base, 16);
    send(1'b0, 26'h20, '0, '0, 8'h41);
    wait_idle();

    // Sparse write: only word 1 (0xF) and word 15 (0xC)
    be = '0; be[7:4] = 4'hF; be[63:62] = 2'b11;
    base = n_wwr;
    send(1'b1, 26'h33, be, rand_line(), 8'h00);
    k = 0;
    do begin @(negedge clk); k++; end while (!mem_req_ready && k < 500);
    chk("sparse_wr_ready_again", k, 17);
    chk("sparse_write_count", n_wwr - base, 2);
    send(1'b0, 26'h33, '0, '0, 8'h42);
    wait_idle();

    // Backpressure: toggling ready, 3-cycle responses, 5-cycle response stall
    ready_mode = 1; rsp_delay = 3; rsp_stall = 5;
    send(1'b0, 26'h10, '0, '0, 8'h5A);
    k = 0;
    while (!mem_rsp_valid && k < 500) begin
      @(negedge clk);
      chk("bp_busy", mem_req_ready, mem_rsp_valid ? 1'b0 : 1'b0);
      k++;
    end
    wait_idle();

    // Spurious word response in IDLE
    ready_mode = 0; rsp_delay = 1; rsp_stall = 0;
    @(negedge clk);
    spur_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("spur_proto_err", proto_err, 1'b1);
    chk("spur_no_rsp", mem_rsp_valid, 1'b0);
    send(1'b0, 26'h20, '0, '0, 8'h66);
    wait_idle();
    chk("spur_sticky", proto_err, 1'b1);

    // Reset mid-read after 7 word issues
    base = n_wrd;
    send(1'b0, 26'h10, '0, '0, 8'h77);
    k = 0;
    while ((n_wrd - base) < 7 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("mid_rd_issued", n_wrd - base, 7);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rsp.delete();
    exp_raddr.delete();
    chk("mid_rst_req_ready", mem_req_ready, 1'b1);
    chk("mid_rst_word_valid", word_req_valid, 1'b0);
    chk("mid_rst_rsp_valid", mem_rsp_valid, 1'b0);
    chk("mid_rst_proto_err", proto_err, 1'b0);
    send(1'b0, 26'h10, '0, '0, 8'h78);
    wait_idle();

    // Randomized mix against the line-level model
    for (int i = 0; i < 40; i++) begin
      ready_mode = $urandom_range(0, 2);
      rsp_delay  = $urandom_range(1, 4);
      rsp_stall  = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int s = 0; s < N; s++) begin
          case ($urandom_range(0, 3))
            0:       be[s*4 +: 4] = 4'h0;
            1:       be[s*4 +: 4] = 4'hF;
            default: be[s*4 +: 4] = 4'($urandom);
          endcase
        end
        send(1'b1, lines[$urandom_range(0, 3)], be, rand_line(), 8'h00);
      end else begin
        send(1'b0, lines[$urandom_range(0, 3)], '0, '0, 8'($urandom));
      end
      wait_idle();
    end

    repeat (5) @(negedge clk);
    chk("final_rsp_q_empty", exp_rsp.size(), 0);
    chk("final_wr_q_empty", exp_wr.size(), 0);
    chk("final_raddr_q_empty", exp_raddr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
